cypher_serializer: RTL and testbench
====================================

Name: cypher_serializer

Overview:
- Downstream stage of the message shifter.
- Captures one shifted MSG_W-bit word on a load strobe and emits it as CHUNK_W-bit beats, MSB chunk first, over a valid/ready stream interface.
- Feeds the byte-wide transmit/output path of the cypher datapath.

Parameters:
- MSG_W, default `MSG_SIZE (from definitions.v): message width in bits. Must be an integer multiple of CHUNK_W.
- CHUNK_W, default 8: beat width in bits.
- N_BEATS, derived as MSG_W/CHUNK_W (localparam): data beats per message.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- en  input  1  load strobe. Sampled only in IDLE.
- in_data  input  MSG_W  shifted message from the shifter stage.
- busy  output  1  high whenever the state is not IDLE.
- out_data  output  CHUNK_W  current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  marks the final beat of a message.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE, shift register=0, beat counter=0. Outputs busy=0, out_valid=0, out_last=0, done=0, out_data=0. Asserting reset mid-message aborts it with no further beats; the first clock edge after release starts in IDLE.
- All outputs are registered or derived from registered state only, with no combinational path from out_ready.
- FSM states: IDLE, SEND, (CSUM when the optional feature is compiled in), DONE.
- IDLE:
  - en=1 at edge k: in_data is latched, counter=0, state goes to SEND.
  - out_valid=1 from edge k (visible in cycle k+1), so latency is 1 cycle.
  - en=0: stay in IDLE.
- SEND:
  - out_data = shift_reg[MSG_W-1 -: CHUNK_W]. out_valid=1.
  - Handshake = out_valid & out_ready at a rising edge. On a handshake: shift left by CHUNK_W (zero-fill) and counter+1.
  - out_last=1 when counter==N_BEATS-1 (without the checksum feature).
  - Handshake on the last beat: go to DONE (or CSUM when the feature is compiled in).
  - While out_ready=0, out_data, out_valid and out_last hold stable. out_valid never drops without a handshake.
- DONE: out_valid=0, done=1 for exactly one cycle, then IDLE. A new message can load no earlier than the cycle after DONE.
- en while busy=1: ignored. No capture, no error, in_data has no effect.
- Counter width: $clog2(N_BEATS+1). The counter never wraps within a message and is cleared on load.
- MSG_W==CHUNK_W (N_BEATS=1): the single beat carries out_last=1.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- Defined:
  - A CHUNK_W XOR accumulator clears on load and XORs each accepted data beat.
  - After the last data beat, the CSUM state emits the accumulator as one extra beat under the same handshake rules. out_last=1 on this beat only; data beats never assert out_last.
  - CSUM then goes to DONE. The message is N_BEATS+1 beats.
- Undefined: no accumulator and no CSUM state. The message is N_BEATS beats and out_last is on the final data beat.

Test Plan:
- Tests use MSG_W=32, CHUNK_W=8.
- Streaming: reset released, in_data=32'hA1B2C3D4, en pulse, out_ready=1 constant -> beats A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after en; out_last only on D4; done=1 one cycle later; then busy=0.
- Backpressure: same word, out_ready=0 for 3 cycles while B2 is presented -> out_data=B2 and out_valid=1 held for all 3 cycles; the sequence resumes C3,D4 unchanged, with no duplicate or lost beat.
- Load while busy: en=1 with in_data=32'hFFFFFFFF during the B2 beat -> output still A1,B2,C3,D4; no second message.
- Reset mid-message: reset=0 asynchronously after the B2 handshake -> out_valid=0, busy=0 immediately. After release, a new load of 32'h01020304 yields 01,02,03,04.
- Back-to-back: en held high continuously with 32'h11223344, then 32'h55667788 presented after done -> second capture happens in IDLE after DONE; sequences are 11,22,33,44 then 55,66,77,88.
- SER_CHECKSUM_EN defined, in_data=32'hA1B2C3D4 -> beats A1,B2,C3,D4,04; out_last only on 04; done after beat 04.

Source files
------------

// File: rtl/cypher_serializer.sv
// Serializes one captured MSG_W-bit word into CHUNK_W-bit beats, MSB chunk first, over valid/ready.
// MSG_W defaults to 32; SER_CHECKSUM_EN appends an XOR checksum beat.
module cypher_serializer #(
  parameter int unsigned MSG_W   = 32,
  parameter int unsigned CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [MSG_W-1:0]   in_data,
  output logic               busy,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned N_BEATS = MSG_W / CHUNK_W;
  localparam int unsigned CNT_W   = $clog2(N_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

`ifdef SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [CHUNK_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               hs;
`ifdef SER_CHECKSUM_EN
  logic [CHUNK_W-1:0] acc_q, acc_d;
`endif

  assign hs = valid_q & out_ready;

  // Next-state logic; output flops are loaded from the next state so they track it exactly.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          shift_d = in_data;
          cnt_d   = '0;
`ifdef SER_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          shift_d = shift_q << CHUNK_W;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef SER_CHECKSUM_EN
          acc_d   = acc_q ^ shift_q[MSG_W-1 -: CHUNK_W];
          if (cnt_q == LAST_CNT) state_d = CSUM;
`else
          if (cnt_q == LAST_CNT) state_d = DONE;
`endif
        end
      end
`ifdef SER_CHECKSUM_EN
      CSUM: begin
        if (hs) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    data_d  = '0;
`ifdef SER_CHECKSUM_EN
    valid_d = (state_d == SEND) || (state_d == CSUM);
    last_d  = (state_d == CSUM);
    if (state_d == SEND)      data_d = shift_d[MSG_W-1 -: CHUNK_W];
    else if (state_d == CSUM) data_d = acc_d;
`else
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (cnt_d == LAST_CNT);
    if (state_d == SEND) data_d = shift_d[MSG_W-1 -: CHUNK_W];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef SER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cypher_serializer.sv
// Scoreboard bench for cypher_serializer (MSG_W=32, CHUNK_W=8); honours SER_CHECKSUM_EN.
module tb_cypher_serializer;

  localparam int unsigned MW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NB = MW / CW;
`ifdef SER_CHECKSUM_EN
  localparam int unsigned TOT = NB + 1;
`else
  localparam int unsigned TOT = NB;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [MW-1:0] in_data = '0;
  logic          busy;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          done;

  cypher_serializer #(.MSG_W(MW), .CHUNK_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .in_data(in_data), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [CW:0] sb[$];          // {last, data}
  logic [CW:0] cur_msg[TOT];   // model beats of the most recently issued message
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slice the word MSB-first with plain arithmetic, optional XOR of all slices.
  task automatic push_msg(input logic [MW-1:0] w);
    logic [CW-1:0] cs = '0;
    logic [CW-1:0] b;
    for (int i = 0; i < int'(NB); i++) begin
      b = CW'((w >> (MW - CW * (i + 1))) & ((1 << CW) - 1));
      cs ^= b;
      cur_msg[i] = {(i == int'(TOT) - 1), b};
      sb.push_back(cur_msg[i]);
    end
    if (TOT > NB) begin
      cur_msg[TOT-1] = {1'b1, cs};
      sb.push_back(cur_msg[TOT-1]);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for IDLE, then issues a one-cycle load; returns in the first beat's cycle.
  task automatic load(input logic [MW-1:0] w);
    int t = 0;
    while (busy && t < 500) begin step(); t++; end
    if (busy) chk("load_wait_timeout", 1, 0);
    en = 1'b1;
    in_data = w;
    push_msg(w);
    step();
    en = 1'b0;
    chk("busy_after_load", busy, 1);
    chk("latency_valid", out_valid, 1);
    chk("first_beat", out_data, cur_msg[0][CW-1:0]);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || sb.size() != 0) && t < 3000) begin step(); t++; end
    chk("drain_timeout", t < 3000, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  always @(posedge clk) if (rand_rdy) begin #1; out_ready = ($urandom_range(0, 3) != 0); end

  // Monitor: pops on every handshake and checks the protocol rules around it.
  bit          exp_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [CW:0] prev_beat = '0;
  logic [CW:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      exp_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_pulse", done, exp_done);
      if (exp_done) chk("valid_in_done", out_valid, 0);
      exp_done = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_last, out_data}, prev_beat);
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      else chk("busy_when_valid", busy, 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", {out_last, out_data}, 0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e[CW-1:0]);
          chk("beat_last", out_last, e[CW]);
          exp_done = e[CW];
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat = {out_last, out_data};
    end
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    #11 reset = 1'b1;
    step();

    // Streaming with out_ready constantly high
    out_ready = 1'b1;
    load(32'hA1B2C3D4);
    for (int i = 0; i < int'(TOT); i++) begin
      chk("stream_data", out_data, cur_msg[i][CW-1:0]);
      chk("stream_last", out_last, cur_msg[i][CW]);
      step();
    end
    chk("stream_done", done, 1);
    chk("stream_done_valid", out_valid, 0);
    step();
    chk("stream_idle_busy", busy, 0);
    chk("stream_idle_done", done, 0);

    // Backpressure on the second beat
    load(32'hA1B2C3D4);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data", out_data, 8'hB2);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle();

    // Load attempt while busy is ignored
    load(32'hA1B2C3D4);
    step();
    en = 1'b1;
    in_data = 32'hFFFFFFFF;
    step();
    en = 1'b0;
    wait_idle();
    repeat (3) step();
    chk("no_second_msg", busy, 0);

    // Reset after the B2 handshake aborts the message
    load(32'hA1B2C3D4);
    step();
    step();
    #2 reset = 1'b0;
    sb.delete();
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", out_data, 0);
    #3 reset = 1'b1;
    step();
    load(32'h01020304);
    wait_idle();

    // en held high across two messages
    en = 1'b1;
    in_data = 32'h11223344;
    push_msg(32'h11223344);
    step();
    chk("b2b_busy", busy, 1);
    in_data = 32'h55667788;
    push_msg(32'h55667788);
    for (int t = 0; t < 50 && busy; t++) step();
    chk("b2b_idle_seen", busy, 0);
    step();
    chk("b2b_second_capture", busy, 1);
    en = 1'b0;
    wait_idle();

    // Randomized words under random backpressure
    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      load($urandom);
      repeat ($urandom_range(0, 6)) step();
    end
    wait_idle();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
